// File: rtl/dram_port_if.sv
// Ready/valid request + response bundle used for both requester ports and the DRAM port.
// ID_W is 3 on the requester side and 4 on the DRAM side (owner bit prepended).
interface dram_port_if #(
  parameter int ID_W = 3
);
  logic            req_valid;
  logic            req_ready;
  logic [ID_W-1:0] req_bits_id;
  logic [31:0]     req_bits_addr;
  logic [127:0]    req_bits_data;
  logic            req_bits_isWr;
  logic [15:0]     req_bits_mask;
  logic            resp_valid;
  logic            resp_ready;
  logic [ID_W-1:0] resp_bits_id;
  logic [127:0]    resp_bits_data;

  // The side that issues requests and consumes responses.
  modport master (
    output req_valid, req_bits_id, req_bits_addr, req_bits_data, req_bits_isWr, req_bits_mask,
    output resp_ready,
    input  req_ready, resp_valid, resp_bits_id, resp_bits_data
  );

  // The side that accepts requests and produces responses.
  modport slave (
    input  req_valid, req_bits_id, req_bits_addr, req_bits_data, req_bits_isWr, req_bits_mask,
    input  resp_ready,
    output req_ready, resp_valid, resp_bits_id, resp_bits_data
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM port between fetch (c0) and data (c1) requesters.
// Requests go through a one-entry output slot; responses are routed back by id bit 3.
module dram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  dram_port_if.slave  c0,
  dram_port_if.slave  c1,
  dram_port_if.master mem,
  output logic        err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [1:0]         req_valid;
  logic [1:0]         elig;
  logic [1:0]         win;
  logic [1:0]         grant;
  logic [1:0]         deliver;
  logic [1:0]         bogus;
  logic [1:0][CW-1:0] outst;
  logic               last;
  logic               run;
  logic               owner;
  logic               slot_free;

  logic               slot_valid;
  logic [3:0]         slot_id;
  logic [31:0]        slot_addr;
  logic [127:0]       slot_data;
  logic               slot_is_wr;
  logic [15:0]        slot_mask;

  assign req_valid = {c1.req_valid, c0.req_valid};
  assign slot_free = ~slot_valid | mem.req_ready;

  // Response path is pure wiring: owner bit selects which requester sees valid.
  assign owner             = mem.resp_bits_id[3];
  assign c0.resp_valid     = mem.resp_valid & ~owner;
  assign c1.resp_valid     = mem.resp_valid & owner;
  assign c0.resp_bits_id   = mem.resp_bits_id[2:0];
  assign c1.resp_bits_id   = mem.resp_bits_id[2:0];
  assign c0.resp_bits_data = mem.resp_bits_data;
  assign c1.resp_bits_data = mem.resp_bits_data;
  assign mem.resp_ready    = owner ? c1.resp_ready : c0.resp_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    elig    = 2'b00;
    win     = 2'b00;
    grant   = 2'b00;
    deliver = 2'b00;
    bogus   = 2'b00;
    for (int n = 0; n < 2; n++) begin
      elig[n] = req_valid[n] & (outst[n] < MAX_CNT);
    end
    // last = 1 means c1 was granted most recently, so c0 wins a tie.
    win[0] = elig[0] & (~elig[1] | last);
    win[1] = elig[1] & (~elig[0] | ~last);
    // run holds grants off for the first cycle after reset as well.
    if (run && !reset && slot_free) begin
      grant = win;
    end
    deliver[0] = mem.resp_valid & mem.resp_ready & ~owner;
    deliver[1] = mem.resp_valid & mem.resp_ready & owner;
    for (int n = 0; n < 2; n++) begin
      bogus[n] = deliver[n] & (outst[n] == '0);
    end
  end

  assign c0.req_ready = grant[0];
  assign c1.req_ready = grant[1];

  assign mem.req_valid     = slot_valid;
  assign mem.req_bits_id   = slot_id;
  assign mem.req_bits_addr = slot_addr;
  assign mem.req_bits_data = slot_data;
  assign mem.req_bits_isWr = slot_is_wr;
  assign mem.req_bits_mask = slot_mask;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      run        <= 1'b0;
      last       <= 1'b1;
      err        <= 1'b0;
      outst      <= '0;
      slot_valid <= 1'b0;
      slot_id    <= '0;
      slot_addr  <= '0;
      slot_data  <= '0;
      slot_is_wr <= 1'b0;
      slot_mask  <= '0;
    end else begin
      run <= 1'b1;

      if (|grant) begin
        slot_valid <= 1'b1;
        slot_id    <= {grant[1], grant[1] ? c1.req_bits_id : c0.req_bits_id};
        slot_addr  <= grant[1] ? c1.req_bits_addr : c0.req_bits_addr;
        slot_data  <= grant[1] ? c1.req_bits_data : c0.req_bits_data;
        slot_is_wr <= grant[1] ? c1.req_bits_isWr : c0.req_bits_isWr;
        slot_mask  <= grant[1] ? c1.req_bits_mask : c0.req_bits_mask;
        last       <= grant[1];
      end else if (slot_valid && mem.req_ready) begin
        slot_valid <= 1'b0;
      end

      // Accept and delivery on the same requester cancel; a delivery never underflows.
      for (int n = 0; n < 2; n++) begin
        if (grant[n] && !deliver[n]) begin
          outst[n] <= outst[n] + 1'b1;
        end else if (deliver[n] && !grant[n] && outst[n] != '0) begin
          outst[n] <= outst[n] - 1'b1;
        end
      end

      if (|bogus) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomised bench for dram_port_arbiter: a driver with an in-bench DRAM model and reference
// model feeds scoreboard queues that a separate monitor checks against the DUT outputs.
module tb_dram_port_arbiter;

  localparam int MAX = 4;

  typedef struct packed {
    logic [3:0]   id;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         is_wr;
    logic [15:0]  mask;
  } req_t;

  typedef struct packed {
    logic         owner;
    logic [2:0]   tag;
    logic [127:0] data;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic err;

  always #5 clock = ~clock;

  dram_port_if #(.ID_W(3)) c0_if ();
  dram_port_if #(.ID_W(3)) c1_if ();
  dram_port_if #(.ID_W(4)) mem_if ();

  dram_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clock (clock),
    .reset (reset),
    .c0    (c0_if),
    .c1    (c1_if),
    .mem   (mem_if),
    .err   (err)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboards: requests expected on the DRAM port, responses expected at the requesters.
  req_t       exp_q[$];
  resp_t      resp_q[$];
  logic [3:0] dram_q[$];

  // Reference model state.
  int   inflight [2];
  bit   m_last;
  bit   m_err;
  bit   err_next;
  bit   acc_now;
  bit   in_reset;

  // DRAM model response register.
  bit           pres_valid;
  logic [3:0]   pres_id;
  logic [127:0] pres_data;

  // Stimulus knobs (percent) and the values driven this cycle.
  int p_v0, p_v1, p_mrdy, p_rrdy, p_resp;
  bit drv_v0, drv_v1, drv_mrdy, drv_r0, drv_r1;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic set_knobs(input int v0, input int v1, input int mrdy, input int rrdy, input int resp);
    p_v0 = v0; p_v1 = v1; p_mrdy = mrdy; p_rrdy = rrdy; p_resp = resp;
  endtask

  task automatic drive_requests();
    c0_if.req_valid     = drv_v0;
    c0_if.req_bits_id   = 3'($urandom);
    c0_if.req_bits_addr = $urandom;
    c0_if.req_bits_data = {$urandom, $urandom, $urandom, $urandom};
    c0_if.req_bits_isWr = 1'($urandom);
    c0_if.req_bits_mask = 16'($urandom);
    c1_if.req_valid     = drv_v1;
    c1_if.req_bits_id   = 3'($urandom);
    c1_if.req_bits_addr = $urandom;
    c1_if.req_bits_data = {$urandom, $urandom, $urandom, $urandom};
    c1_if.req_bits_isWr = 1'($urandom);
    c1_if.req_bits_mask = 16'($urandom);
    mem_if.req_ready    = drv_mrdy;
    c0_if.resp_ready    = drv_r0;
    c1_if.resp_ready    = drv_r1;
    mem_if.resp_valid     = pres_valid;
    mem_if.resp_bits_id   = pres_id;
    mem_if.resp_bits_data = pres_data;
  endtask

  // One clock cycle of stimulus plus reference-model update.
  task automatic step();
    bit slot_busy, slot_free, e0, e1, win1, x0, x1, owner;
    @(negedge clock);
    if (err_next) begin
      m_err    = 1'b1;
      err_next = 1'b0;
    end
    // DRAM returns any previously received request, in random order.
    if (!pres_valid && dram_q.size() > 0 && chance(p_resp)) begin
      int    k;
      resp_t rs;
      k          = int'($urandom_range(dram_q.size() - 1));
      pres_id    = dram_q[k];
      dram_q.delete(k);
      pres_data  = {$urandom, $urandom, $urandom, $urandom};
      pres_valid = 1'b1;
      rs         = resp_t'{pres_id[3], pres_id[2:0], pres_data};
      resp_q.push_back(rs);
    end
    drv_v0   = chance(p_v0);
    drv_v1   = chance(p_v1);
    drv_mrdy = chance(p_mrdy);
    drv_r0   = chance(p_rrdy);
    drv_r1   = chance(p_rrdy);
    drive_requests();
    #1;
    // Slot is busy exactly when an accepted request has not yet been taken by DRAM.
    slot_busy = exp_q.size() > 0;
    slot_free = !slot_busy || drv_mrdy;
    e0   = drv_v0 && inflight[0] < MAX;
    e1   = drv_v1 && inflight[1] < MAX;
    win1 = (e0 && e1) ? !m_last : e1;
    x0   = slot_free && e0 && !win1;
    x1   = slot_free && e1 && win1;
    check("c0_req_ready", c0_if.req_ready, x0);
    check("c1_req_ready", c1_if.req_ready, x1);
    if (slot_busy && drv_mrdy) dram_q.push_back(exp_q[0].id);
    acc_now = x0 || x1;
    if (x0) begin
      exp_q.push_back(req_t'{{1'b0, c0_if.req_bits_id}, c0_if.req_bits_addr, c0_if.req_bits_data,
                             c0_if.req_bits_isWr, c0_if.req_bits_mask});
      m_last = 1'b0;
    end
    if (x1) begin
      exp_q.push_back(req_t'{{1'b1, c1_if.req_bits_id}, c1_if.req_bits_addr, c1_if.req_bits_data,
                             c1_if.req_bits_isWr, c1_if.req_bits_mask});
      m_last = 1'b1;
    end
    if (pres_valid) begin
      owner = pres_id[3];
      if (owner ? drv_r1 : drv_r0) begin
        if (inflight[owner] == 0) err_next = 1'b1;
        else inflight[owner]--;
      end
      if (mem_if.resp_ready) pres_valid = 1'b0;
    end
    if (x0) inflight[0]++;
    if (x1) inflight[1]++;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    in_reset = 1'b1;
    reset    = 1'b1;
    exp_q.delete();
    resp_q.delete();
    dram_q.delete();
    inflight[0] = 0;
    inflight[1] = 0;
    m_last   = 1'b1;
    m_err    = 1'b0;
    err_next = 1'b0;
    acc_now  = 1'b0;
    pres_valid = 1'b0;
    pres_id    = '0;
    pres_data  = '0;
    drv_v0 = 1'b1; drv_v1 = 1'b1; drv_mrdy = 1'b1; drv_r0 = 1'b1; drv_r1 = 1'b1;
    drive_requests();
    #1;
    check("rst_c0_req_ready", c0_if.req_ready, 1'b0);
    check("rst_c1_req_ready", c1_if.req_ready, 1'b0);
    repeat (cycles) begin
      @(posedge clock);
      #1;
      check("rst_mem_req_valid", mem_if.req_valid, 1'b0);
      check("rst_mem_req_id", mem_if.req_bits_id, 4'h0);
      check("rst_mem_req_addr", mem_if.req_bits_addr, 32'h0);
      check("rst_mem_req_data", mem_if.req_bits_data, 128'h0);
      check("rst_mem_req_wrmask", {mem_if.req_bits_isWr, mem_if.req_bits_mask}, 17'h0);
      check("rst_err", err, 1'b0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_c0_req_ready", c0_if.req_ready, 1'b0);
    check("post_rst_c1_req_ready", c1_if.req_ready, 1'b0);
    check("post_rst_mem_req_valid", mem_if.req_valid, 1'b0);
    check("post_rst_err", err, 1'b0);
    in_reset = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    set_knobs(0, 0, 100, 100, 100);
    for (int i = 0; i < 200 && !done; i++) begin
      if (inflight[0] == 0 && inflight[1] == 0 && !pres_valid && exp_q.size() == 0 && dram_q.size() == 0)
        done = 1'b1;
      else
        step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: inflight %0d/%0d still pending, required 0/0", inflight[0], inflight[1]);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of each scoreboard.
  initial begin : monitor
    req_t  er;
    resp_t rr;
    bit    ev;
    forever begin
      @(negedge clock);
      #2;
      if (!in_reset) begin
        check("err", err, m_err);
        ev = exp_q.size() > (acc_now ? 1 : 0);
        check("mem_req_valid", mem_if.req_valid, ev);
        if (ev && mem_if.req_valid) begin
          er = exp_q[0];
          check("mem_req_id", mem_if.req_bits_id, er.id);
          check("mem_req_addr", mem_if.req_bits_addr, er.addr);
          check("mem_req_data", mem_if.req_bits_data, er.data);
          check("mem_req_wrmask", {mem_if.req_bits_isWr, mem_if.req_bits_mask}, {er.is_wr, er.mask});
          if (mem_if.req_ready) void'(exp_q.pop_front());
        end
        check("resp_present", c0_if.resp_valid | c1_if.resp_valid, resp_q.size() > 0);
        if (resp_q.size() > 0) begin
          rr = resp_q[0];
          check("c0_resp_valid", c0_if.resp_valid, !rr.owner);
          check("c1_resp_valid", c1_if.resp_valid, rr.owner);
          check("resp_tag", rr.owner ? c1_if.resp_bits_id : c0_if.resp_bits_id, rr.tag);
          check("resp_data", rr.owner ? c1_if.resp_bits_data : c0_if.resp_bits_data, rr.data);
          check("mem_resp_ready", mem_if.resp_ready, rr.owner ? drv_r1 : drv_r0);
          if (mem_if.resp_ready) void'(resp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    in_reset   = 1'b1;
    pres_valid = 1'b0;
    pres_id    = '0;
    pres_data  = '0;
    drv_v0 = 1'b0; drv_v1 = 1'b0; drv_mrdy = 1'b0; drv_r0 = 1'b0; drv_r1 = 1'b0;
    drive_requests();
    do_reset(3);

    set_knobs(100, 0, 100, 100, 100);   // single fetch requester
    repeat (20) step();
    set_knobs(100, 100, 100, 100, 100); // contention, full throughput
    repeat (60) step();
    drain();
    set_knobs(0, 100, 100, 100, 0);     // c1 hits its cap with no responses
    repeat (10) step();
    set_knobs(100, 100, 100, 100, 0);   // c0 still served while c1 is capped
    repeat (10) step();
    set_knobs(100, 100, 100, 100, 100);
    repeat (30) step();
    set_knobs(80, 80, 30, 100, 60);     // request-side backpressure
    repeat (300) step();
    set_knobs(70, 70, 90, 20, 80);      // response-side backpressure
    repeat (500) step();
    set_knobs(50, 50, 50, 50, 50);
    repeat (1500) step();
    drain();

    // Response for c0 while nothing of c0 is in flight.
    dram_q.push_back(4'h3);
    set_knobs(0, 0, 100, 100, 100);
    repeat (6) step();
    set_knobs(100, 0, 100, 100, 0);     // counter must still be usable after the bogus response
    repeat (10) step();

    do_reset(2);                        // mid-operation reset with requests outstanding
    set_knobs(60, 60, 70, 70, 70);
    repeat (400) step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
